// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the pipe_MIPS32 program loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_DRAIN,
    ST_REGINIT,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int NUM_REGS = 32;
  localparam logic [31:0] HLT_WORD = 32'hFC000000;

endpackage

// File: rtl/mips_prog_loader.sv
// Streams a program into instruction memory, optionally seeds the register file,
// then runs the core until HLT or timeout. Optional: MIPS_LOADER_REG_INIT_EN.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int MAX_CYCLES = 1000,
  parameter int CNT_W      = 16
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              rf_we,
  output logic [4:0]        rf_addr,
  output logic [31:0]       rf_wdata,
  output logic              core_en,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              timeout,
  output logic [ADDR_W:0]   word_count,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam logic [ADDR_W:0]  DEPTH_W  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W:0]  WC_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

`ifdef MIPS_LOADER_REG_INIT_EN
  localparam state_t LOAD_TARGET = ST_REGINIT;
  logic [4:0] rf_cnt;
`else
  localparam state_t LOAD_TARGET = ST_RUN;
  assign rf_we    = 1'b0;
  assign rf_addr  = '0;
  assign rf_wdata = '0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              hs;

  assign hs = s_valid & s_ready;

  // The first RUN cycle only raises core_en, so the final imem/rf write
  // drains before the core starts; halt and budget are checked once enabled.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state       <= ST_LOAD;
      ptr         <= '0;
      s_ready     <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_en     <= 1'b0;
      busy        <= 1'b1;
      done        <= 1'b0;
      ovf         <= 1'b0;
      timeout     <= 1'b0;
      word_count  <= '0;
      cycle_count <= '0;
`ifdef MIPS_LOADER_REG_INIT_EN
      rf_we       <= 1'b0;
      rf_addr     <= '0;
      rf_wdata    <= '0;
      rf_cnt      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
`ifdef MIPS_LOADER_REG_INIT_EN
      rf_we   <= 1'b0;
`endif
      case (state)
        ST_LOAD: begin
          s_ready <= 1'b1;
          if (hs) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= s_data;
            ptr        <= ptr + PTR_ONE;
            if (word_count != DEPTH_W)
              word_count <= word_count + WC_ONE;
            if (s_last) begin
              s_ready <= 1'b0;
              state   <= LOAD_TARGET;
            end else if (&ptr) begin
              ovf   <= 1'b1;
              state <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          if (hs && s_last) begin
            s_ready <= 1'b0;
            state   <= LOAD_TARGET;
          end
        end

`ifdef MIPS_LOADER_REG_INIT_EN
        ST_REGINIT: begin
          rf_we    <= 1'b1;
          rf_addr  <= rf_cnt;
          rf_wdata <= {27'd0, rf_cnt};
          rf_cnt   <= rf_cnt + 5'd1;
          if (rf_cnt == 5'(NUM_REGS - 1))
            state <= ST_RUN;
        end
`endif

        ST_RUN: begin
          if (!core_en) begin
            core_en <= 1'b1;
          end else if (core_halted) begin
            core_en <= 1'b0;
            timeout <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DONE;
          end else begin
            cycle_count <= cycle_count + CNT_ONE;
            if (cycle_count + CNT_ONE == MAX_W) begin
              core_en <= 1'b0;
              timeout <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (restart) begin
            word_count  <= '0;
            cycle_count <= '0;
            ovf         <= 1'b0;
            timeout     <= 1'b0;
            ptr         <= '0;
            s_ready     <= 1'b1;
            done        <= 1'b0;
            busy        <= 1'b1;
            state       <= ST_LOAD;
`ifdef MIPS_LOADER_REG_INIT_EN
            rf_cnt      <= '0;
`endif
          end
        end

        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: instance A (ADDR_W=10) for load/run/restart,
// instance B (ADDR_W=2) for overflow; both use MAX_CYCLES=20 and share stimulus.
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  typedef struct {
    logic [31:0] data;
    bit          last;
    int          gap;
    int          exp_addr;
  } vec_t;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic        clk1 = 1'b0;
  logic        rst, s_valid, s_last, restart, core_halted;
  logic [31:0] s_data;
  bit          sel;

  logic        s_ready_a, imem_we_a, rf_we_a, core_en_a, busy_a, done_a, ovf_a, timeout_a;
  logic [9:0]  imem_addr_a;
  logic [31:0] imem_wdata_a, rf_wdata_a;
  logic [4:0]  rf_addr_a;
  logic [10:0] word_count_a;
  logic [15:0] cycle_count_a;

  logic        s_ready_b, imem_we_b, rf_we_b, core_en_b, busy_b, done_b, ovf_b, timeout_b;
  logic [1:0]  imem_addr_b;
  logic [31:0] imem_wdata_b, rf_wdata_b;
  logic [4:0]  rf_addr_b;
  logic [2:0]  word_count_b;
  logic [15:0] cycle_count_b;

  logic ready_m, core_en_m, done_m;
  assign ready_m   = sel ? s_ready_b : s_ready_a;
  assign core_en_m = sel ? core_en_b : core_en_a;
  assign done_m    = sel ? done_b    : done_a;

  int   total = 0, passed = 0;
  int   run_cnt, rf_count, rf_expect, rf_bad, excl_bad;
  wr_t  log_a[$], log_b[$];
  vec_t prog_v[$], bp_v[$], ov_v[$], two_v[$];

  mips_prog_loader #(.ADDR_W(10), .MAX_CYCLES(20), .CNT_W(16)) dut_a (
    .clk1(clk1), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .s_last(s_last), .restart(restart), .imem_we(imem_we_a), .imem_addr(imem_addr_a),
    .imem_wdata(imem_wdata_a), .rf_we(rf_we_a), .rf_addr(rf_addr_a), .rf_wdata(rf_wdata_a),
    .core_en(core_en_a), .core_halted(core_halted), .busy(busy_a), .done(done_a),
    .ovf(ovf_a), .timeout(timeout_a), .word_count(word_count_a), .cycle_count(cycle_count_a)
  );

  mips_prog_loader #(.ADDR_W(2), .MAX_CYCLES(20), .CNT_W(16)) dut_b (
    .clk1(clk1), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .s_last(s_last), .restart(restart), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
    .imem_wdata(imem_wdata_b), .rf_we(rf_we_b), .rf_addr(rf_addr_b), .rf_wdata(rf_wdata_b),
    .core_en(core_en_b), .core_halted(core_halted), .busy(busy_b), .done(done_b),
    .ovf(ovf_b), .timeout(timeout_b), .word_count(word_count_b), .cycle_count(cycle_count_b)
  );

  always #5 clk1 = ~clk1;

  // Record every write strobe mid-cycle and watch strobe exclusivity on A.
  always @(negedge clk1) begin
    if (imem_we_a) log_a.push_back('{int'(imem_addr_a), imem_wdata_a});
    if (imem_we_b) log_b.push_back('{int'(imem_addr_b), imem_wdata_b});
    if (rf_we_a) begin
      if (rf_addr_a != 5'(rf_expect) || rf_wdata_a != 32'(rf_expect)) rf_bad++;
      rf_expect++;
      rf_count++;
    end
    if (imem_we_a && rf_we_a) excl_bad++;
    if (core_en_a && (imem_we_a || rf_we_a)) excl_bad++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] d, input bit last, input int gap);
    int n = 0;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!ready_m && n < 50) begin
      @(negedge clk1);
      n++;
    end
    checkOutput("s_ready_wait", ready_m, 1);
    @(negedge clk1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic runAndWait(input int halt_at, input int restart_at);
    int n = 0;
    run_cnt = 0;
    while (!done_m && n < 300) begin
      if (core_en_m) begin
        run_cnt++;
        core_halted = (halt_at > 0 && run_cnt >= halt_at);
        restart     = (restart_at > 0 && run_cnt == restart_at);
      end
      @(negedge clk1);
      n++;
    end
    core_halted = 1'b0;
    restart     = 1'b0;
    checkOutput("reached_done", done_m, 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    restart = 1'b0;
    core_halted = 1'b0;
    @(negedge clk1);
    rst = 1'b0;
    @(negedge clk1);
    log_a.delete();
    log_b.delete();
    rf_count = 0;
    rf_expect = 0;
  endtask

  task automatic loadVectors(input vec_t v[$]);
    for (int i = 0; i < v.size(); i++) applyStimulus(v[i].data, v[i].last, v[i].gap);
  endtask

  task automatic compareLog(input vec_t v[$], input bit use_b, input string tag);
    wr_t lg[$];
    int  j = 0;
    if (use_b) lg = log_b;
    else       lg = log_a;
    for (int i = 0; i < v.size(); i++) begin
      if (v[i].exp_addr >= 0) begin
        if (j < lg.size()) begin
          checkOutput({tag, "_addr"}, lg[j].addr, v[i].exp_addr);
          checkOutput({tag, "_data"}, lg[j].data, v[i].data);
        end else begin
          checkOutput({tag, "_missing_write"}, 0, 1);
        end
        j++;
      end
    end
    checkOutput({tag, "_nwrites"}, lg.size(), j);
  endtask

  initial begin
    prog_v.push_back('{32'h2801001E, 1'b0, 0, 0});
    prog_v.push_back('{32'h2802000A, 1'b0, 0, 1});
    prog_v.push_back('{32'h00432820, 1'b0, 0, 2});
    prog_v.push_back('{32'h28240005, 1'b0, 0, 3});
    prog_v.push_back('{HLT_WORD,     1'b1, 0, 4});
    bp_v.push_back('{32'h11110000, 1'b0, 0, 0});
    bp_v.push_back('{32'h11110001, 1'b0, 2, 1});
    bp_v.push_back('{32'h11110002, 1'b0, 1, 2});
    bp_v.push_back('{32'h11110003, 1'b0, 0, 3});
    bp_v.push_back('{32'h11110004, 1'b0, 3, 4});
    bp_v.push_back('{32'h11110005, 1'b0, 0, 5});
    bp_v.push_back('{32'h11110006, 1'b0, 1, 6});
    bp_v.push_back('{32'h11110007, 1'b1, 2, 7});
    ov_v.push_back('{32'hA0000000, 1'b0, 0, 0});
    ov_v.push_back('{32'hA0000001, 1'b0, 0, 1});
    ov_v.push_back('{32'hA0000002, 1'b0, 1, 2});
    ov_v.push_back('{32'hA0000003, 1'b0, 0, 3});
    ov_v.push_back('{32'hA0000004, 1'b0, 0, -1});
    ov_v.push_back('{32'hA0000005, 1'b1, 2, -1});
    two_v.push_back('{32'h20010007, 1'b0, 0, 0});
    two_v.push_back('{HLT_WORD,     1'b1, 1, 1});

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    restart = 1'b0; core_halted = 1'b0; sel = 1'b0;
    run_cnt = 0; rf_count = 0; rf_expect = 0; rf_bad = 0; excl_bad = 0;

    // Reset values while rst is held
    @(negedge clk1); @(negedge clk1);
    checkOutput("rst_s_ready", s_ready_a, 0);
    checkOutput("rst_imem_we", imem_we_a, 0);
    checkOutput("rst_core_en", core_en_a, 0);
    checkOutput("rst_done", done_a, 0);
    checkOutput("rst_busy", busy_a, 1);
    checkOutput("rst_word_count", word_count_a, 0);
    checkOutput("rst_cycle_count", cycle_count_a, 0);
    checkOutput("rst_ovf", ovf_a, 0);
    rst = 1'b0;
    @(negedge clk1);
    checkOutput("s_ready_after_rst", s_ready_a, 1);

    $display("[TB] program load and halt");
    loadVectors(prog_v);
    checkOutput("load_word_count", word_count_a, 5);
    checkOutput("core_en_during_last_write", core_en_a, 0);
    runAndWait(12, 0);
    checkOutput("load_run_cycles", run_cnt, 12);
    checkOutput("load_cycle_count", cycle_count_a, 11);
    checkOutput("load_timeout", timeout_a, 0);
    checkOutput("load_core_en_off", core_en_a, 0);
    checkOutput("load_busy", busy_a, 0);
    compareLog(prog_v, 1'b0, "load");
`ifdef MIPS_LOADER_REG_INIT_EN
    checkOutput("reginit_writes", rf_count, 32);
    checkOutput("reginit_bad", rf_bad, 0);
`endif
    repeat (3) @(negedge clk1);
    checkOutput("done_hold_wc", word_count_a, 5);
    checkOutput("done_hold_done", done_a, 1);

    $display("[TB] restart in DONE, restart ignored in RUN");
    restart = 1'b1;
    @(negedge clk1);
    restart = 1'b0;
    checkOutput("restart_wc", word_count_a, 0);
    checkOutput("restart_cycle_count", cycle_count_a, 0);
    checkOutput("restart_done", done_a, 0);
    checkOutput("restart_busy", busy_a, 1);
    checkOutput("restart_s_ready", s_ready_a, 1);
    log_a.delete();
    rf_expect = 0;
    loadVectors(two_v);
    runAndWait(8, 3);
    checkOutput("run_restart_cycle_count", cycle_count_a, 7);
    checkOutput("run_restart_wc", word_count_a, 2);
    compareLog(two_v, 1'b0, "restart");

    $display("[TB] backpressure");
    doReset();
    loadVectors(bp_v);
    runAndWait(2, 0);
    checkOutput("bp_word_count", word_count_a, 8);
    checkOutput("bp_ovf", ovf_a, 0);
    compareLog(bp_v, 1'b0, "bp");

    $display("[TB] timeout");
    doReset();
    applyStimulus(HLT_WORD, 1'b1, 0);
    checkOutput("one_word_wc", word_count_a, 1);
    runAndWait(0, 0);
    checkOutput("to_timeout", timeout_a, 1);
    checkOutput("to_cycle_count", cycle_count_a, 20);
    checkOutput("to_core_en", core_en_a, 0);
    doReset();
    applyStimulus(HLT_WORD, 1'b1, 0);
    runAndWait(20, 0);
    checkOutput("halt20_timeout", timeout_a, 0);
    checkOutput("halt20_cycle_count", cycle_count_a, 19);

    $display("[TB] overflow on small instance");
    doReset();
    sel = 1'b1;
    loadVectors(ov_v);
    checkOutput("ovf_flag", ovf_b, 1);
    checkOutput("ovf_word_count", word_count_b, 4);
    runAndWait(3, 0);
    checkOutput("ovf_cycle_count", cycle_count_b, 2);
    checkOutput("ovf_flag_held", ovf_b, 1);
    compareLog(ov_v, 1'b1, "ovf");
    sel = 1'b0;

    $display("[TB] reset mid-load");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(32'hC0DE0000 + 32'(i), 1'b0, 0);
    checkOutput("midload_wc_before", word_count_a, 3);
    rst = 1'b1;
    @(negedge clk1);
    checkOutput("midload_rst_wc", word_count_a, 0);
    checkOutput("midload_rst_s_ready", s_ready_a, 0);
    rst = 1'b0;
    @(negedge clk1);
    log_a.delete();
    applyStimulus(32'hBEEF0001, 1'b0, 0);
    @(negedge clk1);
    checkOutput("midload_nwrites", log_a.size(), 1);
    if (log_a.size() > 0) checkOutput("midload_addr", log_a[0].addr, 0);
    checkOutput("midload_wc_after", word_count_a, 1);

`ifndef MIPS_LOADER_REG_INIT_EN
    checkOutput("rf_we_never", rf_count, 0);
`endif
    checkOutput("exclusive_strobes", excl_bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
